action_sequencer: RTL and testbench
===================================

// Module: action_sequencer
// PURPOSE
//   Executes the 64-bit action word shifted in over the host SPI link as eight 8-bit commands.
//   Byte 7 (bits 63:56) runs first, then bytes 6..0 in order.
//   Sequences the shared stepper driver, the laser enable and the ADC SPI master via req/done handshakes.
//   Sits between the SPI slave shift register and the stepper/ADC/laser datapath inside final_project.
// PARAMETERS
//   NCMD      8       commands per action word (action width = 8*NCMD)
//   ADC_W     10      ADC sample width
//   TICK_DIV  10000   clk cycles per WAIT tick (>=2)
// PORTS
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high
//   start        in   1        1-cycle pulse: action word valid (SPI load deasserted)
//   action       in   8*NCMD   command word; sampled only on an accepted start
//   abort        in   1        level; cancels the running sequence
//   busy         out  1        sequence in progress
//   seq_done     out  1        1-cycle pulse at normal completion (not on abort)
//   step_req     out  1        stepper move request (level, held until step_done)
//   step_dir     out  1        direction for the current move
//   step_count   out  5        number of steps for the current move
//   step_done    in   1        stepper finished the move
//   laser_on     out  1        laser enable
//   adc_req      out  1        ADC conversion request (level, held until adc_done)
//   adc_chan     out  3        ADC channel for the current conversion
//   adc_done     in   1        conversion complete; adc_data valid this cycle
//   adc_data     in   ADC_W    conversion result
//   sample       out  ADC_W    last captured result
//   sample_slot  out  3        index (7..0) of the command that produced sample
//   sample_valid out  1        1-cycle pulse when sample/sample_slot update
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0, including sample, sample_slot, laser_on and the timer.
//   Command byte [7:6] opcodes:
//     00 WAIT: [5:0]=n ticks; n=0 means END (stop now, seq_done)
//     01 STEP: [5]=dir, [4:0]=count; count=0 is a NOP
//     10 LASER: [0]=on/off; [5:1] ignored
//     11 SAMPLE: [2:0]=channel; [5:3] ignored
//   States: IDLE, FETCH, STEP, LASER, ADC, WAIT, DONE.
//   IDLE: start accepted -> latch action, idx=NCMD-1, busy=1, FETCH next cycle.
//   FETCH: decode byte[idx] (1 cycle) -> STEP / LASER / ADC / WAIT / DONE.
//     NOP/END go directly to FETCH-next / DONE.
//   STEP: step_req=1 with dir/count stable; on step_done, drop req next cycle, advance.
//   ADC: adc_req=1; on adc_done, capture sample=adc_data and sample_slot=idx, pulse sample_valid next cycle, advance.
//   LASER: laser_on<=[0] in 1 cycle, advance.
//   WAIT: exactly n*TICK_DIV cycles in WAIT, then advance.
//   Advance: idx==0 -> DONE; else idx-1 -> FETCH.
//   DONE: seq_done=1, busy=0, laser_on=0 (safety), -> IDLE.
//     Exactly 1 cycle; a start in DONE is ignored.
//   start while busy: ignored, action not re-latched.
//   done inputs are ignored unless the matching req is high; a done that arrives together with req drop is ignored.
//   abort (any state but IDLE): next cycle IDLE; step_req/adc_req/laser_on/busy=0; no seq_done.
//     A sample captured in the same cycle is still reported.
//   abort has priority over start and over done in the same cycle; reset has priority over all.
//   Reset mid-operation behaves like abort and additionally clears sample/sample_slot.
//   Minimum sequence: 8x LASER = 1+8*2+1 cycles start->seq_done.
// STRUCTURE
//   final_project_pkg: opcode_e {OP_WAIT,OP_STEP,OP_LASER,OP_SAMPLE}; seq_state_e; CMD_W=8; field slice localparams.
//   Sub-module tick_timer (load n, count n*TICK_DIV, expire pulse) instantiated once for WAIT.
//   Everything else is flat in one always_ff FSM plus output registers.
// TESTING
//   action=01_02_03_04_05_06_07_08 (all WAIT), TICK_DIV=4 -> seq_done after 36*4 wait cycles + fetch overhead; no req ever asserted.
//   action=45_80_C3_00_.. -> step_req dir=0 count=5 until step_done; laser_on=0; adc_chan=3; sample_slot=5; then END -> seq_done.
//   Byte 7=81 (laser on) then END -> laser_on high for one cycle, cleared in DONE.
//   Abort during STEP with step_req high -> next cycle step_req=0, busy=0, laser_on=0, no seq_done.
//   start pulsed mid-sequence with a different action -> ignored; original bytes finish.
//   Reset during ADC with adc_done the same cycle -> sample stays 0, no sample_valid.
//   step_done pulsed while idle -> no state change.

Source files
------------

// File: rtl/action_sequencer_pkg.sv
// Shared types and command-field layout for the action word sequencer.
package action_sequencer_pkg;

  localparam int unsigned CMD_W     = 8;
  localparam int unsigned ARG_W     = 6;
  localparam int unsigned DIR_BIT   = 5;
  localparam int unsigned CNT_MSB   = 4;
  localparam int unsigned CHAN_MSB  = 2;
  localparam int unsigned LASER_BIT = 0;

  typedef enum logic [1:0] {
    OP_WAIT   = 2'b00,
    OP_STEP   = 2'b01,
    OP_LASER  = 2'b10,
    OP_SAMPLE = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STEP,
    S_LASER,
    S_ADC,
    S_WAIT,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    opcode_e          op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

endpackage

// File: rtl/action_sequencer_tick_timer.sv
// WAIT timer: after load, expire pulses in the (n*TICK_DIV)-th cycle following the load edge.
module action_sequencer_tick_timer #(
  parameter int unsigned TICK_DIV = 10000,
  parameter int unsigned N_W      = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           clear,
  input  logic [N_W-1:0] n,
  output logic           expire
);

  localparam int unsigned CNT_W = $clog2(((2 ** N_W) - 1) * TICK_DIV + 1);

  logic [CNT_W-1:0] rem;
  logic             active;

  // rem counts down to 1; the registered expire then lands on the final cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rem    <= '0;
      active <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (load) begin
        rem    <= CNT_W'(n) * CNT_W'(TICK_DIV) - CNT_W'(1);
        active <= 1'b1;
      end else if (active) begin
        rem <= rem - CNT_W'(1);
        if (rem == CNT_W'(1)) begin
          expire <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/action_sequencer.sv
// Runs the eight commands of a latched action word (byte NCMD-1 first) against the
// stepper, laser and ADC through req/done handshakes.
module action_sequencer
  import action_sequencer_pkg::*;
#(
  parameter int unsigned NCMD     = 8,
  parameter int unsigned ADC_W    = 10,
  parameter int unsigned TICK_DIV = 10000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CMD_W*NCMD-1:0]   action,
  input  logic                    abort,
  output logic                    busy,
  output logic                    seq_done,
  output logic                    step_req,
  output logic                    step_dir,
  output logic [4:0]              step_count,
  input  logic                    step_done,
  output logic                    laser_on,
  output logic                    adc_req,
  output logic [2:0]              adc_chan,
  input  logic                    adc_done,
  input  logic [ADC_W-1:0]        adc_data,
  output logic [ADC_W-1:0]        sample,
  output logic [$clog2(NCMD)-1:0] sample_slot,
  output logic                    sample_valid
);

  localparam int unsigned IDX_W = $clog2(NCMD);

  seq_state_e             state_q, state_d;
  logic [CMD_W*NCMD-1:0]  act_q, act_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  cmd_t                   cmd;
  logic                   advance_c, timer_load_c, timer_expire;
  logic                   busy_d, seq_done_d, step_req_d, step_dir_d, laser_on_d, adc_req_d;
  logic                   sample_valid_d;
  logic [4:0]             step_count_d;
  logic [2:0]             adc_chan_d;
  logic [ADC_W-1:0]       sample_d;
  logic [IDX_W-1:0]       sample_slot_d;

  // Current command byte selected by idx
  always_comb begin
    cmd = '0;
    for (int i = 0; i < NCMD; i++) begin
      if (idx_q == IDX_W'(i)) cmd = act_q[i*CMD_W +: CMD_W];
    end
  end

  action_sequencer_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .N_W      (ARG_W)
  ) u_tick_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load_c),
    .clear  (abort),
    .n      (cmd.arg),
    .expire (timer_expire)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    act_d          = act_q;
    idx_d          = idx_q;
    advance_c      = 1'b0;
    timer_load_c   = 1'b0;
    step_req_d     = step_req;
    step_dir_d     = step_dir;
    step_count_d   = step_count;
    laser_on_d     = laser_on;
    adc_req_d      = adc_req;
    adc_chan_d     = adc_chan;
    sample_d       = sample;
    sample_slot_d  = sample_slot;
    sample_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          act_d   = action;
          idx_d   = IDX_W'(NCMD - 1);
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        case (cmd.op)
          OP_WAIT: begin
            if (cmd.arg == '0) begin
              state_d = S_DONE;
            end else begin
              state_d      = S_WAIT;
              timer_load_c = 1'b1;
            end
          end
          OP_STEP: begin
            if (cmd.arg[CNT_MSB:0] == '0) begin
              advance_c = 1'b1;
            end else begin
              state_d      = S_STEP;
              step_req_d   = 1'b1;
              step_dir_d   = cmd.arg[DIR_BIT];
              step_count_d = cmd.arg[CNT_MSB:0];
            end
          end
          OP_LASER: state_d = S_LASER;
          OP_SAMPLE: begin
            state_d    = S_ADC;
            adc_req_d  = 1'b1;
            adc_chan_d = cmd.arg[CHAN_MSB:0];
          end
        endcase
      end
      S_STEP: begin
        if (step_req && step_done) begin
          step_req_d = 1'b0;
          advance_c  = 1'b1;
        end
      end
      S_ADC: begin
        if (adc_req && adc_done) begin
          adc_req_d      = 1'b0;
          sample_d       = adc_data;
          sample_slot_d  = idx_q;
          sample_valid_d = 1'b1;
          advance_c      = 1'b1;
        end
      end
      S_LASER: begin
        laser_on_d = cmd.arg[LASER_BIT];
        advance_c  = 1'b1;
      end
      S_WAIT: begin
        if (timer_expire) advance_c = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance_c) begin
      if (idx_q == '0) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q - IDX_W'(1);
        state_d = S_FETCH;
      end
    end

    // Abort wins over done/start; a sample captured this cycle is still reported
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      step_req_d   = 1'b0;
      adc_req_d    = 1'b0;
      laser_on_d   = 1'b0;
      timer_load_c = 1'b0;
    end

    if (state_d == S_DONE) laser_on_d = 1'b0;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    seq_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      act_q        <= '0;
      idx_q        <= '0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      step_req     <= 1'b0;
      step_dir     <= 1'b0;
      step_count   <= '0;
      laser_on     <= 1'b0;
      adc_req      <= 1'b0;
      adc_chan     <= '0;
      sample       <= '0;
      sample_slot  <= '0;
      sample_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      idx_q        <= idx_d;
      busy         <= busy_d;
      seq_done     <= seq_done_d;
      step_req     <= step_req_d;
      step_dir     <= step_dir_d;
      step_count   <= step_count_d;
      laser_on     <= laser_on_d;
      adc_req      <= adc_req_d;
      adc_chan     <= adc_chan_d;
      sample       <= sample_d;
      sample_slot  <= sample_slot_d;
      sample_valid <= sample_valid_d;
    end
  end

endmodule

// File: tb/tb_action_sequencer.sv
// Randomized bench for action_sequencer with a command-level timing/event model.
module tb_action_sequencer;

  localparam int unsigned NCMD  = 8;
  localparam int unsigned ADC_W = 10;
  localparam int unsigned TD    = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort, step_done, adc_done;
  logic [63:0] action;
  logic [9:0]  adc_data;
  logic        busy, seq_done, step_req, step_dir, laser_on, adc_req, sample_valid;
  logic [4:0]  step_count;
  logic [2:0]  adc_chan, sample_slot;
  logic [9:0]  sample;

  int tests_run    = 0;
  int tests_failed = 0;

  action_sequencer #(.NCMD(NCMD), .ADC_W(ADC_W), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start(start), .action(action), .abort(abort),
    .busy(busy), .seq_done(seq_done), .step_req(step_req), .step_dir(step_dir),
    .step_count(step_count), .step_done(step_done), .laser_on(laser_on),
    .adc_req(adc_req), .adc_chan(adc_chan), .adc_done(adc_done), .adc_data(adc_data),
    .sample(sample), .sample_slot(sample_slot), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    logic [7:0]  b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       b = {2'b00, 6'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3))};
        1:       b = {2'b01, 6'($urandom)};
        2:       b = {2'b10, 6'($urandom)};
        default: b = {2'b11, 6'($urandom)};
      endcase
      w = {w[55:0], b};
    end
    return w;
  endfunction

  // Model the word at command level, then run it with randomized done latencies
  task automatic run_seq(input logic [63:0] act, input int start_at, input bit hold_done,
                         input string name);
    int cur = 1, lvl = 0, on_since = 0, lon = 0, exp_done, inj, t = 0, lcnt = 0;
    int d, op, arg, e, sdly = 0, adly = 0, adat = 0;
    int mv_q[$], sd_q[$], ch_q[$], ad_q[$], dat_q[$], smp_q[$];
    bit s_act = 0, a_act = 0, s_last = 0, a_last = 0, done_seen = 0;
    logic [7:0] b;
    for (int i = NCMD - 1; i >= 0; i--) begin
      b   = 8'(act >> (8 * i));
      op  = int'(b[7:6]);
      arg = int'(b[5:0]);
      cur++;
      if (op == 0 && arg == 0) break;
      case (op)
        0: cur += arg * TD;
        1: if (arg % 32 != 0) begin
             d = int'($urandom_range(0, 3));
             mv_q.push_back(arg); sd_q.push_back(d); cur += d + 1;
           end
        2: begin
             if (lvl == 0 && arg % 2 == 1) on_since = cur + 1;
             if (lvl == 1 && arg % 2 == 0) lon += cur + 1 - on_since;
             lvl = arg % 2; cur += 1;
           end
        default: begin
             d = int'($urandom_range(0, 3));
             e = int'($urandom_range(0, 1023));
             ch_q.push_back(arg % 8); ad_q.push_back(d); dat_q.push_back(e);
             smp_q.push_back(e * 8 + i); cur += d + 1;
           end
      endcase
    end
    exp_done = cur;
    if (lvl == 1) lon += exp_done - on_since;
    inj = (start_at < 0) ? exp_done : start_at;

    @(negedge clk); start = 1'b1; action = act;
    while (!done_seen && t <= exp_done + 20) begin
      @(negedge clk);
      t++;
      start  = (t == inj);
      action = (t == inj) ? ~act : {$urandom, $urandom};
      if (laser_on) lcnt++;
      if (sample_valid) begin
        tests_run++;
        if (smp_q.size() == 0) begin
          tests_failed++; $display("FAIL %s sample_valid: got unexpected pulse, want none", name);
        end else begin
          e = smp_q.pop_front();
          if ({sample, sample_slot} !== 13'(e)) begin
            tests_failed++;
            $display("FAIL %s sample: got %0d slot %0d, want %0d slot %0d", name, sample,
                     sample_slot, e / 8, e % 8);
          end
        end
      end
      if (step_req) begin
        if (!s_act) begin
          s_act = 1; tests_run++;
          if (mv_q.size() == 0) begin
            tests_failed++; $display("FAIL %s step_req: got unexpected request, want none", name);
            sdly = 0;
          end else begin
            e = mv_q.pop_front(); sdly = sd_q.pop_front();
            if ({step_dir, step_count} !== 6'(e)) begin
              tests_failed++;
              $display("FAIL %s step move: got dir %0d count %0d, want dir %0d count %0d",
                       name, step_dir, step_count, e / 32, e % 32);
            end
          end
        end
        if (sdly == 0) begin step_done = 1'b1; s_last = 1; end
        else begin sdly--; step_done = 1'b0; end
      end else begin
        s_act = 0; step_done = hold_done && s_last; s_last = 0;
      end
      if (adc_req) begin
        if (!a_act) begin
          a_act = 1; tests_run++;
          if (ch_q.size() == 0) begin
            tests_failed++; $display("FAIL %s adc_req: got unexpected request, want none", name);
            adly = 0; adat = 0;
          end else begin
            e = ch_q.pop_front(); adly = ad_q.pop_front(); adat = dat_q.pop_front();
            if (adc_chan !== 3'(e)) begin
              tests_failed++;
              $display("FAIL %s adc_chan: got %0d, want %0d", name, adc_chan, e);
            end
          end
        end
        if (adly == 0) begin adc_done = 1'b1; adc_data = 10'(adat); a_last = 1; end
        else begin adly--; adc_done = 1'b0; end
      end else begin
        a_act = 0; adc_done = hold_done && a_last; a_last = 0;
      end
      if (seq_done) begin
        done_seen = 1;
        tests_run++;
        if (t != exp_done) begin
          tests_failed++; $display("FAIL %s latency: got %0d, want %0d", name, t, exp_done);
        end
        tests_run++;
        if ({laser_on, busy} !== 2'b00) begin
          tests_failed++;
          $display("FAIL %s done outputs: got laser %0b busy %0b, want 0 0", name, laser_on, busy);
        end
      end
    end
    if (!done_seen) begin
      tests_run++; tests_failed++;
      $display("FAIL %s seq_done: got none in %0d cycles, want cycle %0d", name, t, exp_done);
    end
    @(negedge clk); start = 1'b0; step_done = 1'b0; adc_done = 1'b0;
    tests_run++;
    if ({busy, seq_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s after done: got busy %0b seq_done %0b, want 0 0", name, busy, seq_done);
    end
    tests_run++;
    if (mv_q.size() + ch_q.size() + smp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s pending events: got %0d left, want 0", name,
               mv_q.size() + ch_q.size() + smp_q.size());
    end
    tests_run++;
    if (lcnt != lon) begin
      tests_failed++; $display("FAIL %s laser cycles: got %0d, want %0d", name, lcnt, lon);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; step_done = 1'b0; adc_done = 1'b0;
    action = '0; adc_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({busy, seq_done, step_req, adc_req, laser_on, sample_valid} !== 6'b0) begin
      tests_failed++; $display("FAIL reset flags: got %06b, want 000000",
                               {busy, seq_done, step_req, adc_req, laser_on, sample_valid});
    end
    tests_run++;
    if ({sample, sample_slot, step_dir, step_count, adc_chan} !== 22'b0) begin
      tests_failed++; $display("FAIL reset data: got %0h, want 0",
                               {sample, sample_slot, step_dir, step_count, adc_chan});
    end
  endtask

  task automatic test_idle_done();
    int bad = 0;
    @(negedge clk); step_done = 1'b1; adc_done = 1'b1; adc_data = 10'h155;
    repeat (3) begin
      @(negedge clk); step_done = 1'b0; adc_done = 1'b0;
      if ({busy, seq_done, step_req, adc_req, sample_valid} !== 5'b0 || sample !== 10'h0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL idle_done: got %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_abort();
    bit seen = 0;
    int bad = 0;
    logic [9:0] v;
    @(negedge clk); start = 1'b1; action = 64'h814A_0000_0000_0000;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (step_req) seen = 1; else @(negedge clk);
    end
    tests_run++;
    if (!seen || laser_on !== 1'b1) begin
      tests_failed++; $display("FAIL abort_step setup: got req %0b laser %0b, want 1 1", seen, laser_on);
    end
    abort = 1'b1; step_done = 1'b1;
    @(negedge clk); abort = 1'b0; step_done = 1'b0;
    tests_run++;
    if ({step_req, busy, laser_on, seq_done} !== 4'b0) begin
      tests_failed++; $display("FAIL abort_step outputs: got %04b, want 0000",
                               {step_req, busy, laser_on, seq_done});
    end
    repeat (6) begin
      @(negedge clk);
      if (seq_done || busy || step_req) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL abort_step quiet: got %0d active cycles, want 0", bad);
    end

    seen = 0;
    @(negedge clk); start = 1'b1; action = 64'hC200_0000_0000_0000;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (adc_req) seen = 1; else @(negedge clk);
    end
    v = 10'($urandom_range(1, 1023));
    abort = 1'b1; adc_done = 1'b1; adc_data = v;
    @(negedge clk); abort = 1'b0; adc_done = 1'b0;
    tests_run++;
    if (!seen || {sample_valid, sample, sample_slot} !== {1'b1, v, 3'd7}) begin
      tests_failed++; $display("FAIL abort_adc sample: got valid %0b %0h slot %0d, want 1 %0h slot 7",
                               sample_valid, sample, sample_slot, v);
    end
    tests_run++;
    if ({busy, adc_req, seq_done} !== 3'b0) begin
      tests_failed++; $display("FAIL abort_adc outputs: got %03b, want 000", {busy, adc_req, seq_done});
    end
  endtask

  task automatic test_reset_adc();
    bit seen = 0;
    @(negedge clk); start = 1'b1; action = 64'hC500_0000_0000_0000;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (adc_req) seen = 1; else @(negedge clk);
    end
    reset = 1'b1; adc_done = 1'b1; adc_data = 10'h3FF;
    @(negedge clk); reset = 1'b0; adc_done = 1'b0;
    tests_run++;
    if (!seen || {sample_valid, sample, sample_slot} !== 14'b0) begin
      tests_failed++; $display("FAIL reset_adc sample: got valid %0b %0h slot %0d, want 0 0 0",
                               sample_valid, sample, sample_slot);
    end
    @(negedge clk);
    tests_run++;
    if ({busy, adc_req, sample_valid, seq_done} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_adc outputs: got %04b, want 0000",
                               {busy, adc_req, sample_valid, seq_done});
    end
  endtask

  task automatic test_commands();
    logic [63:0] w;
    run_seq(64'h0102_0304_0506_0708, 0, 1'b0, "all_wait");
    run_seq({32'h4580_C300, $urandom}, 0, 1'b1, "mixed");
    w = {$urandom, $urandom}; w[63:48] = 16'h8100;
    run_seq(w, 0, 1'b0, "laser_end");
    for (int i = 0; i < 8; i++) w = {w[55:0], 2'b10, 6'($urandom)};
    run_seq(w, 0, 1'b0, "min_laser");
  endtask

  task automatic test_start_ignored();
    logic [63:0] w;
    w = rand_word(); w[63:56] = 8'h43;
    run_seq(w, 2, 1'b0, "start_mid");
    run_seq(rand_word(), -1, 1'b0, "start_in_done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) run_seq(rand_word(), 0, 1'($urandom), "random");
  endtask

  initial begin
    test_reset();
    test_idle_done();
    test_commands();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_reset_adc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
